// File: rtl/serial_nios_mem_arb_pkg.sv
// Shared defaults, response codes and owner type for the serial NIOS memory arbiter.
// Optional macro SERIAL_MEM_ARB_ERR_EN uses the response codes defined here.
package serial_nios_mem_arb_pkg;

  localparam int DEFAULT_ADDR_W    = 12;
  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_NUM_WORDS = 2560;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  typedef enum logic {
    OWNER_M0 = 1'b0,
    OWNER_M1 = 1'b1
  } owner_e;

endpackage

// File: rtl/serial_nios_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, one-bit preference pointer.
module serial_nios_rr_arb2
  import serial_nios_mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  owner_e ptr_q, ptr_d;

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (!reset) begin
      if (req_i[0] && (ptr_q == OWNER_M0 || !req_i[1])) begin
        gnt_o = 2'b01;
        ptr_d = OWNER_M1;
      end else if (req_i[1]) begin
        gnt_o = 2'b10;
        ptr_d = OWNER_M0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= OWNER_M0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/serial_nios_mem_arbiter.sv
// Two Avalon-MM masters sharing one single-port on-chip RAM, one access per cycle.
// Macro SERIAL_MEM_ARB_ERR_EN adds address range checking with mN_response and err_addr.
module serial_nios_mem_arbiter
  import serial_nios_mem_arb_pkg::*;
#(
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int NUM_WORDS = DEFAULT_NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
`ifdef SERIAL_MEM_ARB_ERR_EN
  output logic [1:0]            m0_response,
  output logic [1:0]            m1_response,
  output logic [ADDR_W-1:0]     err_addr,
`endif
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata
);

  logic [1:0]          req, gnt;
  logic                accept, mem_ok;
  owner_e              sel_owner;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_write;
  logic [DATA_W-1:0]   ret_data;

  logic                rd_pend_q, rd_pend_d;
  owner_e              rd_owner_q, rd_owner_d;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  serial_nios_rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req_i (req),
    .gnt_o (gnt)
  );

  assign accept    = |gnt;
  assign sel_owner = gnt[1] ? OWNER_M1 : OWNER_M0;
  assign sel_addr  = gnt[1] ? m1_address : m0_address;
  assign sel_write = gnt[1] ? m1_write : m0_write;

  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];

`ifdef SERIAL_MEM_ARB_ERR_EN
  logic              addr_bad;
  logic              rd_err_q, rd_err_d;
  logic              err_seen_q, err_seen_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  assign addr_bad   = accept && (32'(sel_addr) >= 32'(NUM_WORDS));
  assign mem_ok     = ~addr_bad;
  assign rd_err_d   = addr_bad;
  assign err_seen_d = err_seen_q | addr_bad;
  // Only the first out-of-range address is kept until reset.
  assign err_addr_d = (addr_bad && !err_seen_q) ? sel_addr : err_addr_q;
  assign err_addr   = err_addr_q;
`else
  assign mem_ok = 1'b1;
`endif

  assign mem_address    = sel_addr;
  assign mem_byteenable = gnt[1] ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = gnt[1] ? m1_writedata : m0_writedata;
  assign mem_chipselect = accept & mem_ok;
  assign mem_write      = accept & sel_write & mem_ok;
  assign mem_clken      = ~reset;

  assign rd_pend_d  = accept & ~sel_write;
  assign rd_owner_d = sel_owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= OWNER_M0;
`ifdef SERIAL_MEM_ARB_ERR_EN
      rd_err_q   <= 1'b0;
      err_seen_q <= 1'b0;
      err_addr_q <= '0;
`endif
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
`ifdef SERIAL_MEM_ARB_ERR_EN
      rd_err_q   <= rd_err_d;
      err_seen_q <= err_seen_d;
      err_addr_q <= err_addr_d;
`endif
    end
  end

  // A return still in flight when reset rises is suppressed in that same cycle.
  always_comb begin
    ret_data         = mem_readdata;
    m0_readdatavalid = rd_pend_q && (rd_owner_q == OWNER_M0) && !reset;
    m1_readdatavalid = rd_pend_q && (rd_owner_q == OWNER_M1) && !reset;
`ifdef SERIAL_MEM_ARB_ERR_EN
    if (rd_err_q) ret_data = '0;
    m0_response = (m0_readdatavalid && rd_err_q) ? SLVERR : OKAY;
    m1_response = (m1_readdatavalid && rd_err_q) ? SLVERR : OKAY;
`endif
    m0_readdata = m0_readdatavalid ? ret_data : '0;
    m1_readdata = m1_readdatavalid ? ret_data : '0;
  end

endmodule

// File: tb/tb_serial_nios_mem_arbiter.sv
// Self-checking bench: RAM model, round-robin predictor and read-return scoreboard.
module tb_serial_nios_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int NW = 2560;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct packed {
    logic          owner;
    logic [DW-1:0] data;
    logic [1:0]    resp;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [AW-1:0] m0_address = '0, m1_address = '0;
  logic m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [BW-1:0] m0_byteenable = '0, m1_byteenable = '0;
  logic [DW-1:0] m0_writedata = '0, m1_writedata = '0;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DW-1:0] m0_readdata, m1_readdata;
`ifdef SERIAL_MEM_ARB_ERR_EN
  logic [1:0] m0_response, m1_response;
  logic [AW-1:0] err_addr;
`endif
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic [DW-1:0] mem_writedata;
  logic mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_readdata;

  logic [DW-1:0] ram [0:NW-1];
  logic [DW-1:0] model [0:NW-1];
  exp_t exp_q[$];
  logic ptr;
  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_nios_mem_arbiter dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_byteenable    (m0_byteenable),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_byteenable    (m1_byteenable),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
`ifdef SERIAL_MEM_ARB_ERR_EN
    .m0_response      (m0_response),
    .m1_response      (m1_response),
    .err_addr         (err_addr),
`endif
    .mem_address      (mem_address),
    .mem_byteenable   (mem_byteenable),
    .mem_writedata    (mem_writedata),
    .mem_chipselect   (mem_chipselect),
    .mem_write        (mem_write),
    .mem_clken        (mem_clken),
    .mem_readdata     (mem_readdata)
  );

  // RAM with registered read: data appears the cycle after the address.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end
      mem_readdata <= ram[mem_address];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic req_t rd(input int a);
    rd = '{rd: 1'b1, wr: 1'b0, a: AW'(a), be: '1, wd: '0};
  endfunction

  function automatic req_t wr(input int a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    wr = '{rd: 1'b0, wr: 1'b1, a: AW'(a), be: be, wd: d};
  endfunction

  localparam req_t IDLE = '0;

  // One clock cycle: drive, check returns and grant, update model, advance.
  task automatic step(input logic rst, input req_t r0, input req_t r1);
    logic q0, q1, acc, g1, bad;
    req_t rs;
    exp_t e;
    reset = rst;
    m0_address = r0.a; m0_read = r0.rd; m0_write = r0.wr; m0_byteenable = r0.be; m0_writedata = r0.wd;
    m1_address = r1.a; m1_read = r1.rd; m1_write = r1.wr; m1_byteenable = r1.be; m1_writedata = r1.wd;
    #1;
    if (rst) exp_q.delete();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rvalid0", m0_readdatavalid, !e.owner);
      check("rvalid1", m1_readdatavalid, e.owner);
      check("rdata", e.owner ? m1_readdata : m0_readdata, e.data);
      check("rdata_idle", e.owner ? m0_readdata : m1_readdata, 0);
`ifdef SERIAL_MEM_ARB_ERR_EN
      check("resp", e.owner ? m1_response : m0_response, e.resp);
`endif
    end else begin
      check("no_rvalid", {m1_readdatavalid, m0_readdatavalid}, 0);
      check("rdata_zero", {m1_readdata, m0_readdata}, 0);
    end
    q0 = r0.rd | r0.wr;
    q1 = r1.rd | r1.wr;
    acc = 1'b0; g1 = 1'b0;
    if (!rst) begin
      if (q0 && (ptr == 1'b0 || !q1)) acc = 1'b1;
      else if (q1) begin acc = 1'b1; g1 = 1'b1; end
    end
    rs = g1 ? r1 : r0;
    bad = 1'b0;
`ifdef SERIAL_MEM_ARB_ERR_EN
    bad = acc && (int'(rs.a) >= NW);
`endif
    check("wait0", m0_waitrequest, !(acc && !g1));
    check("wait1", m1_waitrequest, !(acc && g1));
    check("chipsel", mem_chipselect, acc && !bad);
    check("mem_write", mem_write, acc && rs.wr && !bad);
    check("clken", mem_clken, !rst);
    if (acc) begin
      check("mem_addr", mem_address, rs.a);
      if (rs.wr) begin
        check("mem_wdata", {mem_byteenable, mem_writedata}, {rs.be, rs.wd});
        if (!bad)
          for (int b = 0; b < BW; b++)
            if (rs.be[b]) model[rs.a][8*b +: 8] = rs.wd[8*b +: 8];
      end else begin
        e.owner = g1;
        e.data  = bad ? '0 : model[rs.a];
        e.resp  = bad ? 2'b10 : 2'b00;
        exp_q.push_back(e);
      end
      ptr = ~g1;
    end
    if (rst) ptr = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NW; i++) begin
      ram[i]   = {16'hC0DE ^ 16'(i * 7), 16'(i)};
      model[i] = ram[i];
    end
    ptr = 1'b0;

    // Reset with both masters requesting: nothing may be accepted.
    step(1'b1, rd(1), rd(2));
    step(1'b1, rd(3), wr(4, '1, 32'h1234_5678));
`ifdef SERIAL_MEM_ARB_ERR_EN
    check("err_addr_rst", err_addr, 0);
`endif

    // Lone m0 read of 0x010.
    step(1'b0, rd('h010), IDLE);
    step(1'b0, IDLE, IDLE);

    // Continuous reads from both after reset alternate m0, m1, ...
    step(1'b1, IDLE, IDLE);
    for (int i = 0; i < 8; i++) step(1'b0, rd(16 + i), rd(100 + i));
    step(1'b0, IDLE, IDLE);

    // Partial write by m1 then read back by m0.
    step(1'b0, IDLE, wr('h020, 4'b0011, 32'hA5A5_A5A5));
    step(1'b0, rd('h020), IDLE);
    step(1'b0, IDLE, IDLE);
    check("be_merge", model['h020], {16'hC0DE ^ 16'('h020 * 7), 16'hA5A5});

    // Mixed random traffic including the top legal word.
    for (int i = 0; i < 60; i++) begin
      req_t a, b;
      int aa, ab;
      aa = ($urandom_range(0, 7) == 0) ? NW - 1 : int'($urandom_range(0, 31));
      ab = ($urandom_range(0, 7) == 0) ? NW - 1 : int'($urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: a = IDLE;
        1: a = wr(aa, 4'($urandom), $urandom);
        default: a = rd(aa);
      endcase
      case ($urandom_range(0, 3))
        0: b = IDLE;
        1: b = wr(ab, 4'($urandom), $urandom);
        default: b = rd(ab);
      endcase
      if ($urandom_range(0, 9) == 0) begin a.rd = 1'b1; a.wr = 1'b1; end
      step(1'b0, a, b);
    end
    step(1'b0, IDLE, IDLE);

    // Reset the cycle after an m0 read accept drops the return; m0 wins next.
    step(1'b0, rd(5), IDLE);
    step(1'b1, rd(6), rd(7));
    step(1'b0, rd(8), rd(9));
    step(1'b0, IDLE, IDLE);

`ifdef SERIAL_MEM_ARB_ERR_EN
    step(1'b0, rd(NW), IDLE);
    check("err_addr", err_addr, NW);
    step(1'b0, IDLE, rd(NW + 40));
    check("err_sticky", err_addr, NW);
    step(1'b0, rd(NW - 1), wr(NW + 1, '1, 32'hDEAD_BEEF));
    step(1'b0, IDLE, IDLE);
    step(1'b0, IDLE, IDLE);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
